snake_render_sched: RTL and testbench
=====================================

Name: snake_render_sched

Overview:
- Per-scanline scheduler that feeds snake body segments into the VGA row-buffer renderer.
- Owns the single read port of the snake body RAM (ring of segment records) and shares it between the render walk and game-logic reads; the render walk always has priority.
- On each line_start pulse, walks the body from head to tail and emits one segment per cycle on the renderer's snake_* interface, with first/last flags.

Parameters:
- MAX_LEN, 64, ring depth / maximum snake length (power of two)
- AW, 6, ring address width, log2(MAX_LEN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- line_start  in  1  1-cycle pulse; begin walk for the next scanline
- head_ptr  in  AW  ring index of the head segment
- snake_len  in  AW+1  segment count, 0..MAX_LEN
- mem_rd  out  1  RAM read strobe
- mem_addr  out  AW  RAM read address
- mem_data  in  11  {dir[1:0], y[3:0], x[4:0]}; valid the cycle after mem_rd
- game_req  in  1  game-logic read request
- game_addr  in  AW  game-logic read address
- game_gnt  out  1  read granted this cycle (combinational)
- game_rvalid  out  1  mem_data belongs to game read (1 cycle after grant)
- snake_x  out  5  segment tile x
- snake_y  out  4  segment tile y
- snake_dir  out  2  segment direction
- snake_first  out  1  segment is head
- snake_last  out  1  segment is tail
- snake_valid  out  1  segment fields valid
- busy  out  1  walk in progress (state != IDLE)
- overrun  out  1  1-cycle pulse: line_start arrived while busy

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset is asynchronous and takes effect mid-walk: the walk is abandoned and no further snake_valid is emitted.
- States: IDLE, READ, DRAIN.
- IDLE + line_start:
  - Latch hp=head_ptr and n=min(snake_len, MAX_LEN); i=0.
  - If n==0, stay IDLE and emit nothing.
  - Otherwise go to READ.
- READ, one read per cycle:
  - mem_rd=1, mem_addr=(hp - i) mod MAX_LEN (wraps modulo 2^AW).
  - Tag the read with first=(i==0) and last=(i==n-1).
  - Then i++. After the read with i==n-1, go to DRAIN.
- Output pipeline:
  - The read tag is registered alongside the RAM latency.
  - snake_* are registered from mem_data and the tag, so snake_valid rises 2 cycles after the matching mem_rd.
  - First snake_valid = line_start + 3 cycles.
  - Segments appear on consecutive cycles, n valid cycles total.
- DRAIN: waits until the last segment has been output (2 cycles), then returns to IDLE. busy is high in READ and DRAIN.
- n==1: a single segment with snake_first=snake_last=1.
- line_start while busy:
  - Pulse overrun.
  - Discard in-flight reads (their tags are cleared, so no snake_valid).
  - Re-latch inputs and restart at i=0 next cycle.
- Arbitration:
  - game_gnt = game_req && state==IDLE && !line_start. Render wins on a simultaneous request.
  - On grant: mem_rd=1, mem_addr=game_addr; game_rvalid=1 the next cycle.
  - A game read granted in the cycle before line_start completes normally; its data cycle does not collide with render data, which arrives later.
- head_ptr/snake_len changes during a walk are ignored until the next line_start.
- mem_rd=0 whenever there is no grant and no render read; mem_addr is don't-care then.

Decomposition:
- Package snake_pkg holds:
  - MAX_LEN, AW
  - dir_t enum (UP, RIGHT, DOWN, LEFT)
  - seg_t packed struct {dir_t dir; logic[3:0] y; logic[4:0] x}, 11 bits, shared with the body RAM and game logic
- No sub-module needed. The 2-stage tag pipeline (valid/first/last) stays inline.

Test Plan:
- head_ptr=5, snake_len=3, RAM[5]=(x3,y2,R), RAM[4]=(x2,y2,R), RAM[3]=(x1,y2,R); pulse line_start at T -> mem_addr 5,4,3 at T+1..T+3; snake_valid T+3..T+5 with x 3,2,1; first at T+3 only, last at T+5 only; busy drops at T+6.
- head_ptr=1, snake_len=4 -> addresses 1,0,63,62 (wrap); 4 valid outputs.
- snake_len=0, and separately snake_len=1 -> no mem_rd and no snake_valid; one output with first=last=1.
- game_req held while line_start pulses -> game_gnt=0 during line_start and the walk; granted the first IDLE cycle after the walk, game_rvalid 1 cycle later, snake_valid never asserted for it.
- snake_len=40, second line_start 10 cycles into the walk -> overrun pulse; no stale segments from the first walk after the restart; 40 clean segments follow.
- Assert rst_n low mid-walk (len=20) -> all outputs 0 immediately; after release, IDLE and no snake_valid until the next line_start.

Source files
------------

// File: rtl/snake_render_sched_pkg.sv
// Shared types for the snake body RAM, the render scheduler and game logic.
// A seg_t is the 11-bit record stored in each body RAM entry.
package snake_pkg;

    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned AW      = 6;

    typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_t;

    typedef struct packed {
        dir_t       dir;
        logic [3:0] y;
        logic [4:0] x;
    } seg_t;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

endpackage

// File: rtl/snake_render_sched_if.sv
// Body RAM read port, game-logic read port and renderer segment stream.
// The scheduler takes the master side; RAM, game logic and renderer take the slave side.
interface snake_render_sched_if #(
    parameter int unsigned AW = 6
);
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [10:0]   mem_data;

    logic          game_req;
    logic [AW-1:0] game_addr;
    logic          game_gnt;
    logic          game_rvalid;

    logic [4:0]    snake_x;
    logic [3:0]    snake_y;
    logic [1:0]    snake_dir;
    logic          snake_first;
    logic          snake_last;
    logic          snake_valid;

    modport master (
        output mem_rd, mem_addr,
        input  mem_data,
        input  game_req, game_addr,
        output game_gnt, game_rvalid,
        output snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_data,
        output game_req, game_addr,
        input  game_gnt, game_rvalid,
        input  snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
    );
endinterface

// File: rtl/snake_render_sched.sv
// Per-scanline walk of the snake body ring, head to tail, one segment per cycle.
// Shares the single RAM read port with game-logic reads; the render walk has priority.
module snake_render_sched
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN = snake_pkg::MAX_LEN,
    parameter int unsigned AW      = snake_pkg::AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_start,
    input  logic [AW-1:0]         head_ptr,
    input  logic [AW:0]           snake_len,
    snake_render_sched_if.master  bus,
    output logic                  busy,
    output logic                  overrun
);

    state_t        state_q, state_d;
    logic [AW-1:0] hp_q, hp_d;
    logic [AW:0]   n_q, n_d, i_q, i_d, n_new;

    logic          rd_tag, rd_first, rd_last;
    logic          mem_rd_c, game_gnt_c;
    logic [AW-1:0] mem_addr_c;

    logic          t1_valid_q, t1_first_q, t1_last_q;
    logic          out_valid_q, out_first_q, out_last_q;
    seg_t          out_seg_q;
    logic          game_rvalid_q, overrun_q;

    assign n_new = (snake_len > (AW+1)'(MAX_LEN)) ? (AW+1)'(MAX_LEN) : snake_len;
    assign busy  = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        n_d        = n_q;
        i_d        = i_q;
        rd_tag     = 1'b0;
        rd_first   = 1'b0;
        rd_last    = 1'b0;
        mem_rd_c   = 1'b0;
        mem_addr_c = '0;
        game_gnt_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.game_req && !line_start) begin
                    game_gnt_c = 1'b1;
                    mem_rd_c   = 1'b1;
                    mem_addr_c = bus.game_addr;
                end
            end
            READ: begin
                mem_rd_c   = 1'b1;
                mem_addr_c = hp_q - i_q[AW-1:0];
                rd_tag     = 1'b1;
                rd_first   = (i_q == '0);
                rd_last    = (i_q == n_q - (AW+1)'(1));
                i_d        = i_q + (AW+1)'(1);
                if (rd_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_valid_q && out_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new line always restarts; the read issued this cycle is untagged so it never surfaces
        if (line_start) begin
            hp_d    = head_ptr;
            n_d     = n_new;
            i_d     = '0;
            state_d = (n_new == '0) ? IDLE : READ;
            rd_tag  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hp_q          <= '0;
            n_q           <= '0;
            i_q           <= '0;
            t1_valid_q    <= 1'b0;
            t1_first_q    <= 1'b0;
            t1_last_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_first_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_seg_q     <= '0;
            game_rvalid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hp_q          <= hp_d;
            n_q           <= n_d;
            i_q           <= i_d;
            t1_valid_q    <= rd_tag;
            t1_first_q    <= rd_first;
            t1_last_q     <= rd_last;
            // Stage-1 tag belongs to the abandoned walk when a new line starts
            out_valid_q   <= t1_valid_q && !line_start;
            out_first_q   <= t1_first_q && !line_start;
            out_last_q    <= t1_last_q && !line_start;
            if (t1_valid_q) out_seg_q <= seg_t'(bus.mem_data);
            game_rvalid_q <= game_gnt_c;
            overrun_q     <= line_start && busy;
        end
    end

    assign bus.mem_rd      = mem_rd_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.game_gnt    = game_gnt_c;
    assign bus.game_rvalid = game_rvalid_q;
    assign bus.snake_x     = out_seg_q.x;
    assign bus.snake_y     = out_seg_q.y;
    assign bus.snake_dir   = out_seg_q.dir;
    assign bus.snake_first = out_first_q;
    assign bus.snake_last  = out_last_q;
    assign bus.snake_valid = out_valid_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_snake_render_sched.sv
// Randomized and directed bench for snake_render_sched against a cycle-schedule model.
// Each line_start schedules its reads, segments and busy window; a restart purges later entries.
module tb_snake_render_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_start = 1'b0;
    logic [5:0] head_ptr = '0;
    logic [6:0] snake_len = '0;
    logic       busy, overrun;

    snake_render_sched_if #(.AW(6)) bus ();

    snake_render_sched #(.MAX_LEN(64), .AW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .head_ptr   (head_ptr),
        .snake_len  (snake_len),
        .bus        (bus),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    logic [10:0] ram [64];
    always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ov_expected = 0;
    int ov_seen = 0;

    bit          exp_busy  [int];
    logic [5:0]  exp_raddr [int];
    logic [5:0]  exp_gaddr [int];
    bit          exp_rv    [int];
    logic [12:0] exp_out   [int];
    bit          ov_ok     [int];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic purge_after(int c);
        int q[$];
        q = {};
        foreach (exp_busy[k])  if (k > c) q.push_back(k);
        foreach (q[j]) exp_busy.delete(q[j]);
        q = {};
        foreach (exp_raddr[k]) if (k > c) q.push_back(k);
        foreach (q[j]) exp_raddr.delete(q[j]);
        q = {};
        foreach (exp_out[k])   if (k > c) q.push_back(k);
        foreach (q[j]) exp_out.delete(q[j]);
    endtask

    task automatic model_step(int c, bit ls, logic [5:0] hp, logic [6:0] len,
                              bit greq, logic [5:0] gaddr);
        bit was_busy;
        int n;
        logic [5:0] a;
        was_busy = exp_busy.exists(c);
        if (greq && !ls && !was_busy) begin
            exp_gaddr[c]  = gaddr;
            exp_rv[c + 1] = 1'b1;
        end
        if (ls) begin
            n = (int'(len) > 64) ? 64 : int'(len);
            if (was_busy) begin
                ov_expected++;
                ov_ok[c]     = 1'b1;
                ov_ok[c + 1] = 1'b1;
            end
            purge_after(c);
            for (int k = 0; k < n; k++) begin
                a = 6'(int'(hp) - k);
                exp_raddr[c + 1 + k] = a;
                exp_out[c + 3 + k]   = {ram[a], 1'(k == 0), 1'(k == n - 1)};
            end
            if (n > 0)
                for (int k = 1; k <= n + 2; k++) exp_busy[c + k] = 1'b1;
        end
    endtask

    task automatic check_cycle(int c);
        bit er;
        er = exp_raddr.exists(c) || exp_gaddr.exists(c);
        check("mem_rd", bus.mem_rd, er);
        if (er)
            check("mem_addr", bus.mem_addr, exp_raddr.exists(c) ? exp_raddr[c] : exp_gaddr[c]);
        check("game_gnt", bus.game_gnt, exp_gaddr.exists(c));
        check("game_rvalid", bus.game_rvalid, exp_rv.exists(c));
        check("snake_valid", bus.snake_valid, exp_out.exists(c));
        if (exp_out.exists(c))
            check("segment", {bus.snake_dir, bus.snake_y, bus.snake_x,
                              bus.snake_first, bus.snake_last}, exp_out[c]);
        check("busy", busy, exp_busy.exists(c));
        if (overrun) begin
            ov_seen++;
            check("overrun_window", ov_ok.exists(c), 1);
        end
        exp_busy.delete(c);
        exp_raddr.delete(c);
        exp_gaddr.delete(c);
        exp_rv.delete(c);
        exp_out.delete(c);
        ov_ok.delete(c - 1);
    endtask

    task automatic tick(bit ls, logic [5:0] hp, logic [6:0] len, bit greq, logic [5:0] gaddr);
        line_start    = ls;
        head_ptr      = hp;
        snake_len     = len;
        bus.game_req  = greq;
        bus.game_addr = gaddr;
        model_step(cyc, ls, hp, len, greq, gaddr);
        @(negedge clk);
        check_cycle(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n, bit greq);
        for (int k = 0; k < n; k++)
            tick(1'b0, 6'($urandom), 7'($urandom), greq, 6'($urandom));
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_outs"}, {bus.mem_rd, bus.game_gnt, bus.game_rvalid, bus.snake_valid,
                               bus.snake_first, bus.snake_last, busy, overrun}, 0);
        check({tag, "_seg"}, {bus.snake_dir, bus.snake_y, bus.snake_x}, 0);
    endtask

    initial begin
        foreach (ram[k]) ram[k] = 11'($urandom);
        ram[5] = {2'd1, 4'd2, 5'd3};
        ram[4] = {2'd1, 4'd2, 5'd2};
        ram[3] = {2'd1, 4'd2, 5'd1};
        bus.game_req  = 1'b0;
        bus.game_addr = '0;
        bus.mem_data  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic walk, wrap, empty and single-segment lines
        tick(1'b1, 6'd5, 7'd3, 1'b0, '0);  idle(8, 1'b0);
        tick(1'b1, 6'd1, 7'd4, 1'b0, '0);  idle(8, 1'b0);
        tick(1'b1, 6'd9, 7'd0, 1'b0, '0);  idle(4, 1'b0);
        tick(1'b1, 6'd9, 7'd1, 1'b0, '0);  idle(5, 1'b0);
        tick(1'b1, 6'd2, 7'd100, 1'b0, '0); idle(70, 1'b0);

        // game reads held across a line start
        idle(3, 1'b1);
        tick(1'b1, 6'd20, 7'd5, 1'b1, 6'd33);
        idle(12, 1'b1);

        // restart mid-walk
        tick(1'b1, 6'd50, 7'd40, 1'b0, '0);
        idle(9, 1'b0);
        tick(1'b1, 6'd7, 7'd40, 1'b0, '0);
        idle(46, 1'b0);
        check("overrun_count", ov_seen, ov_expected);

        // asynchronous reset mid-walk
        tick(1'b1, 6'd30, 7'd20, 1'b0, '0);
        idle(8, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midwalk_reset");
        exp_busy.delete(); exp_raddr.delete(); exp_gaddr.delete();
        exp_rv.delete(); exp_out.delete(); ov_ok.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        idle(25, 1'b0);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            bit       ls;
            logic [6:0] len;
            ls  = ($urandom_range(0, 24) == 0);
            len = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                               : 7'($urandom_range(0, 12));
            tick(ls, 6'($urandom), len, 1'($urandom), 6'($urandom));
        end
        idle(80, 1'b0);
        check("overrun_count_final", ov_seen, ov_expected);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
